// File: rtl/instr_word_encoder_stream_pkg.sv
`default_nettype none
// ============================================================================
// instr_word_encoder_stream_pkg
//   Shared types and constants for the RISC-V instruction word encoder.
//   Rev 1.0
// ============================================================================
package instr_word_encoder_stream_pkg;

   // Same encoding as the field decoder; codes 6 and 7 are unknown types.
   typedef enum logic [2:0] {
      IT_R = 3'd0,
      IT_I = 3'd1,
      IT_S = 3'd2,
      IT_B = 3'd3,
      IT_J = 3'd4,
      IT_U = 3'd5
   } instr_type_enum;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;

   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMM13_MIN = -4096;
   localparam int IMM13_MAX = 4094;
   localparam int IMM21_MIN = -(1 << 20);
   localparam int IMM21_MAX = (1 << 20) - 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FULL = 2'd2
   } enc_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_word_encoder_stream_pack.sv
`default_nettype none
// ============================================================================
// instr_word_pack
//   Combinational field-to-word packer with a legality flag.
//   ENCODER_RANGE_CHECK_EN: when defined, out-of-range immediates are illegal.
//   Rev 1.0
// ============================================================================
module instr_word_pack
   import instr_word_encoder_stream_pkg::*;
(
   input  instr_type_enum instr_type_i,
   input  logic [6:0]     opcode_i,
   input  logic [4:0]     rd_i,
   input  logic [2:0]     funct3_i,
   input  logic [4:0]     rs1_i,
   input  logic [4:0]     rs2_i,
   input  logic [6:0]     funct7_i,
   input  logic [31:0]    imm_i,
   output logic [31:0]    word_o,
   output logic           legal_o
);

`ifdef ENCODER_RANGE_CHECK_EN
   logic signed [31:0] w_simm;
   assign w_simm = signed'(imm_i);
`endif

   always_comb begin
      word_o  = 32'h0;
      legal_o = 1'b0;
      case (instr_type_i)
         IT_R: begin
            word_o  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            legal_o = 1'b1;
         end
         IT_I: begin
            word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
            legal_o = (w_simm >= IMM12_MIN) && (w_simm <= IMM12_MAX);
`else
            legal_o = 1'b1;
`endif
         end
         IT_S: begin
            word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
            legal_o = (w_simm >= IMM12_MIN) && (w_simm <= IMM12_MAX);
`else
            legal_o = 1'b1;
`endif
         end
         IT_B: begin
            word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
            legal_o = (w_simm >= IMM13_MIN) && (w_simm <= IMM13_MAX) && !imm_i[0];
`else
            legal_o = 1'b1;
`endif
         end
         IT_J: begin
            word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
            legal_o = (w_simm >= IMM21_MIN) && (w_simm <= IMM21_MAX) && !imm_i[0];
`else
            legal_o = 1'b1;
`endif
         end
         IT_U: begin
            word_o  = {imm_i[31:12], rd_i, opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
            legal_o = (imm_i[11:0] == 12'h000);
`else
            legal_o = 1'b1;
`endif
         end
         default: begin
            word_o  = 32'h0;
            legal_o = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/instr_word_encoder_stream.sv
`default_nettype none
// ============================================================================
// instr_word_encoder_stream
//   Packs field tuples into instruction words and emits sequential IMEM writes.
//   ENCODER_RANGE_CHECK_EN: enables immediate range checks in instr_word_pack.
//   Rev 1.0
// ============================================================================
module instr_word_encoder_stream
   import instr_word_encoder_stream_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 256
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  instr_type_enum               instr_type,
   input  logic [6:0]                   opcode,
   input  logic [4:0]                   rd,
   input  logic [2:0]                   funct3,
   input  logic [4:0]                   rs1,
   input  logic [4:0]                   rs2,
   input  logic [6:0]                   funct7,
   input  logic [31:0]                  imm,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_addr,
   output logic [31:0]                  out_word,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         err
);

   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   enc_state_e    state_q, state_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_addr_q, out_addr_d;
   logic [31:0]   out_word_q, out_word_d;
   logic [31:0]   next_addr_q, next_addr_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;

   logic [31:0]   w_word;
   logic          w_legal;
   logic          w_full;
   logic          w_in_ready;
   logic          w_accept;

   instr_word_pack u_pack (
      .instr_type_i (instr_type),
      .opcode_i     (opcode),
      .rd_i         (rd),
      .funct3_i     (funct3),
      .rs1_i        (rs1),
      .rs2_i        (rs2),
      .funct7_i     (funct7),
      .imm_i        (imm),
      .word_o       (w_word),
      .legal_o      (w_legal)
   );

   assign w_full = (count_q == DEPTH_C);
   // Output register may be refilled in the same cycle it drains.
   assign w_in_ready = (state_q == ST_RUN) && !start && !w_full &&
                       (!out_valid_q || out_ready);
   assign w_accept   = in_valid && w_in_ready;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_word_d  = out_word_q;
      next_addr_d = next_addr_q;
      count_d     = count_q;
      err_d       = err_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (w_accept) begin
         if (w_legal) begin
            out_valid_d = 1'b1;
            out_word_d  = w_word;
            out_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + 32'd4;
            count_d     = count_q + CW'(1);
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!start && (count_d == DEPTH_C)) state_d = ST_FULL;
         end
         ST_FULL: begin
            if (start) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase

      // Rewind leaves any registered word in place so it still drains.
      if (start) begin
         state_d     = ST_RUN;
         next_addr_d = BASE_ADDR;
         count_d     = '0;
         err_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_addr_q  <= 32'h0;
         out_word_q  <= 32'h0;
         next_addr_q <= BASE_ADDR;
         count_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_word_q  <= out_word_d;
         next_addr_q <= next_addr_d;
         count_q     <= count_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_word  = out_word_q;
   assign count     = count_q;
   assign full      = w_full;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_word_encoder_stream.sv
`default_nettype none
// ============================================================================
// tb_instr_word_encoder_stream
//   Scoreboard bench: driver predicts writes from a field-level model, monitor
//   pops and compares on every completed write. Rev 1.0
// ============================================================================
module tb_instr_word_encoder_stream;
   import instr_word_encoder_stream_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          CW    = $clog2(DEPTH + 1);

   logic           clk = 1'b0;
   logic           reset, start, in_valid, in_ready, out_valid, out_ready;
   instr_type_enum instr_type;
   logic [6:0]     opcode, funct7;
   logic [4:0]     rd, rs1, rs2;
   logic [2:0]     funct3;
   logic [31:0]    imm, out_addr, out_word;
   logic [CW-1:0]  count;
   logic           full, err;

   instr_word_encoder_stream #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .instr_type(instr_type), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
      .rs2(rs2), .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_word(out_word), .count(count), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] word;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          m_run   = 1'b0;
   int          m_count = 0;
   logic [31:0] m_addr  = BASE;
   bit          m_err   = 1'b0;
   bit          m_pend  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference packing written straight from the ISA field layout.
   function automatic logic [31:0] ref_word(input logic [2:0] t, input logic [6:0] op,
         input logic [4:0] d, input logic [2:0] f3, input logic [4:0] s1,
         input logic [4:0] s2, input logic [6:0] f7, input logic [31:0] im);
      case (t)
         3'd0:    return {f7, s2, s1, f3, d, op};
         3'd1:    return {im[11:0], s1, f3, d, op};
         3'd2:    return {im[11:5], s2, s1, f3, im[4:0], op};
         3'd3:    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
         3'd4:    return {im[20], im[10:1], im[11], im[19:12], d, op};
         3'd5:    return {im[31:12], d, op};
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit ref_legal(input logic [2:0] t, input logic [31:0] im);
      longint v;
      v = longint'($signed(im));
      if (t > 3'd5) return 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
      case (t)
         3'd1, 3'd2: return (v >= -2048) && (v <= 2047);
         3'd3:       return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
         3'd4:       return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
         3'd5:       return (im % 4096) == 0;
         default:    return 1'b1;
      endcase
`else
      return (v == v);
`endif
   endfunction

   // One clock of stimulus; model state is compared, then advanced.
   task automatic cycle(input bit st, input bit iv, input logic [2:0] t, input logic [6:0] op,
         input logic [4:0] d, input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
         input logic [6:0] f7, input logic [31:0] im, input bit ordy,
         input bit use_exp, input logic [31:0] exp_word);
      bit exp_rdy;
      logic [31:0] w;
      @(posedge clk);
      #1;
      start = st; in_valid = iv; instr_type = instr_type_enum'(t); opcode = op; rd = d;
      funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im; out_ready = ordy;
      @(negedge clk);
      check("count", 32'(count), m_count);
      check("err", 32'(err), 32'(m_err));
      check("full", 32'(full), 32'(m_count == DEPTH));
      check("out_valid", 32'(out_valid), 32'(m_pend));
      exp_rdy = m_run && !st && (m_count < DEPTH) && (!m_pend || ordy);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (m_pend && ordy) m_pend = 1'b0;
      if (st) begin
         m_run = 1'b1; m_count = 0; m_addr = BASE; m_err = 1'b0;
      end else if (iv && exp_rdy) begin
         if (ref_legal(t, im)) begin
            w = use_exp ? exp_word : ref_word(t, op, d, f3, s1, s2, f7, im);
            sb_q.push_back('{m_addr, w});
            m_addr  = m_addr + 32'd4;
            m_count = m_count + 1;
            m_pend  = 1'b1;
         end else begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic idle(input bit ordy);
      cycle(1'b0, 1'b0, 3'd0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0, ordy, 1'b0, 32'h0);
   endtask

   task automatic do_start();
      cycle(1'b1, 1'b0, 3'd0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0, 1'b1, 1'b0, 32'h0);
   endtask

   // Monitor: completed writes are popped; stalled outputs must stay put.
   bit          hold = 1'b0;
   logic [31:0] h_addr, h_word;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_addr", out_addr, h_addr);
               check("hold_word", out_word, h_word);
            end
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_write: addr %h word %h, nothing expected", out_addr, out_word);
               end else begin
                  e = sb_q.pop_front();
                  check("write_addr", out_addr, e.addr);
                  check("write_word", out_word, e.word);
               end
            end
            hold   = out_valid && !out_ready;
            h_addr = out_addr;
            h_word = out_word;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                   1048574, 1048576, -1048576, -1048578};

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr_type = IT_R; opcode = 7'h0; rd = 5'd0; funct3 = 3'd0; rs1 = 5'd0;
      rs2 = 5'd0; funct7 = 7'h0; imm = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_addr", out_addr, 32'd0);
      check("rst_out_word", out_word, 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // IDLE ignores tuples.
      cycle(0, 1, 3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd5, 1, 0, 32'h0);
      // addi x1, x0, 5
      do_start();
      cycle(0, 1, 3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd5, 1, 1, 32'h0050_0093);
      idle(1);
      // sw x2, 8(x1) then beq x0, x0, -4
      do_start();
      cycle(0, 1, 3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h0, 32'd8, 1, 1, 32'h0020_A423);
      cycle(0, 1, 3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, -32'sd4, 1, 1, 32'hFE00_0EE3);
      idle(1);
      // jal x1, 2048 then lui x5, 0x12345
      do_start();
      cycle(0, 1, 3'd4, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd2048, 1, 1, 32'h0010_00EF);
      cycle(0, 1, 3'd5, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h0, 32'h1234_5000, 1, 1, 32'h1234_52B7);
      idle(1);
      // Unknown type sets err without a write; start clears it.
      do_start();
      cycle(0, 1, 3'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd1, 1, 0, 32'h0);
      idle(1);
`ifdef ENCODER_RANGE_CHECK_EN
      do_start();
      cycle(0, 1, 3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd2048, 1, 0, 32'h0);
      idle(1);
`endif
      do_start();
      idle(1);
      // Backpressure then fill to DEPTH.
      do_start();
      cycle(0, 1, 3'd1, 7'h13, 5'd3, 3'd0, 5'd4, 5'd0, 7'h0, 32'd100, 1, 0, 32'h0);
      repeat (3) cycle(0, 1, 3'd1, 7'h13, 5'd3, 3'd0, 5'd4, 5'd0, 7'h0, 32'd200, 0, 0, 32'h0);
      repeat (3) cycle(0, 1, 3'd0, 7'h33, 5'd7, 3'd1, 5'd8, 5'd9, 7'h20, 32'h0, 1, 0, 32'h0);
      cycle(0, 1, 3'd0, 7'h33, 5'd7, 3'd1, 5'd8, 5'd9, 7'h20, 32'h0, 1, 0, 32'h0);
      idle(1);
      idle(1);

      for (int i = 0; i < 400; i++) begin
         int          r, m;
         logic [2:0]  t;
         logic [31:0] rimm;
         r = int'($urandom_range(0, 15));
         t = (r >= 14) ? 3'(r - 8) : 3'(r % 6);
         m = int'($urandom_range(0, 3));
         case (m)
            0:       rimm = 32'(int'($urandom_range(0, 10000)) - 5000);
            1:       rimm = $urandom;
            2:       rimm = $urandom & 32'hFFFF_F000;
            default: rimm = 32'(bnd[$urandom_range(0, 11)]);
         endcase
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 7), t,
               7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
               7'($urandom), rimm, ($urandom_range(0, 9) < 7), 0, 32'h0);
      end
      repeat (3) idle(1);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      // Asynchronous reset while a word is pending.
      do_start();
      cycle(0, 1, 3'd1, 7'h13, 5'd2, 3'd0, 5'd1, 5'd0, 7'h0, 32'd7, 0, 0, 32'h0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      m_run = 1'b0; m_count = 0; m_addr = BASE; m_err = 1'b0; m_pend = 1'b0;
      sb_q.delete();
      @(posedge clk); #1 reset = 1'b0;
      cycle(0, 1, 3'd1, 7'h13, 5'd2, 3'd0, 5'd1, 5'd0, 7'h0, 32'd7, 1, 0, 32'h0);
      idle(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_word_encoder_stream.md
Name: instr_word_encoder_stream

Overview:
- Streaming RISC-V instruction encoder; the inverse of the field decoder.
- Accepts decoded fields plus an instruction type over a valid/ready handshake and packs them into a 32-bit instruction word.
- Writes the words to sequential instruction-memory addresses through a registered output port.
- Used by the test/boot loader to fill IMEM from a field-level stimulus stream.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.
- DEPTH, 256, maximum words emitted per run; must be ≥1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: rewinds address and count, enters RUN.
- in_valid  input  1  field tuple valid.
- in_ready  output  1  block accepts the tuple this cycle.
- instr_type  input  instr_type_enum  R/I/S/B/J/U.
- opcode  input  7  opcode field.
- rd  input  5  destination register.
- funct3  input  3  funct3 field.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct7  input  7  funct7 field.
- imm  input  32  full sign-extended immediate value (not pre-shifted).
- out_valid  output  1  out_addr/out_word hold a valid write.
- out_ready  input  1  memory accepts the write.
- out_addr  output  32  byte address.
- out_word  output  32  encoded instruction.
- count  output  $clog2(DEPTH+1)  words emitted in the current run.
- full  output  1  count == DEPTH.
- err  output  1  sticky range error, cleared by start.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM states:
  - IDLE: in_ready=0. On start → RUN with count=0 and next address=BASE_ADDR.
  - RUN: in_ready = !full && (!out_valid || out_ready). When count reaches DEPTH → FULL.
  - FULL: in_ready=0. The pending output still drains. On start → RUN (rewind).
- start in RUN or FULL:
  - Rewinds count, address and err.
  - An out_valid word already registered is still held until out_ready; it is not discarded.
  - A tuple presented in the same cycle as start is not accepted (in_ready forced 0 that cycle).
- Handshake:
  - Transfer on in_valid && in_ready.
  - out_word/out_addr are registered, so latency from accept to out_valid is 1 cycle.
  - A write completes on out_valid && out_ready.
  - Outputs hold stable while out_valid && !out_ready.
  - Back-to-back throughput is 1 word/cycle when out_ready is held high.
- Bit packing (imm bits refer to the input value):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Address and count on each accepted legal tuple: address += 4 (wraps modulo 2^32), count += 1.
- Unknown instr_type: treated as a range error.
- Range error: the tuple is consumed, no word is emitted, address and count are unchanged, err is set.
- Asynchronous reset mid-run: drops the pending word immediately and returns to IDLE.

Optional Feature:
- Macro: ENCODER_RANGE_CHECK_EN.
- Defined: a tuple is illegal if
  - I/S imm is outside [-2048, 2047];
  - B imm is outside [-4096, 4094] or odd;
  - J imm is outside [-2^20, 2^20-2] or odd;
  - U imm[11:0] ≠ 0.
- Not defined:
  - Immediates are silently truncated to their fields.
  - Only an unknown instr_type sets err.

Decomposition:
- Shared package:
  - instr_type_enum (already shared with the decoder).
  - Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, LUI, AUIPC).
  - Immediate min/max constants.
  - Encoder FSM state enum.
- Sub-module: instr_word_pack, purely combinational. Inputs: fields + type. Outputs: word and a legal flag. Contains the range logic under the macro.
- instr_word_encoder_stream holds the FSM, counters and output register.

Test Plan:
- addi: start, then I, opcode 0x13, rd=1, rs1=0, f3=0, imm=5 → next cycle out_word=0x00500093, out_addr=BASE_ADDR, count=1.
- sw then beq:
  - S, op 0x23, f3=2, rs1=1, rs2=2, imm=8 → 0x0020A423 at BASE+0.
  - B, op 0x63, rs1=rs2=0, imm=-4 → 0xFE000EE3 at BASE+4.
- jal and lui:
  - J, op 0x6F, rd=1, imm=2048 → 0x001000EF.
  - U, op 0x37, rd=5, imm=0x12345000 → 0x123452B7.
- Range error (macro defined): I, imm=2048 → no out_valid, err=1, count unchanged. Then start → err=0.
- Backpressure and full: DEPTH=4, out_ready held low 3 cycles → out_word stable and in_ready=0. After 4 words → full=1, in_ready=0; a further tuple is not accepted.
- Reset mid-stream: assert reset while out_valid=1 → out_valid=0 immediately, count=0, IDLE (in_ready=0 until start).
